reg_file_sb: RTL and testbench

- Parametrised successor to the 2-read/1-write datapath register file.
- Adds a write enable, a hardwired zero register, and a per-register busy scoreboard for pipeline hazard detection.
- Sits in the decode stage:
  - Issue logic reserves a destination register.
  - Writeback writes the register and releases it.
  - Decode reads operands together with their busy flags to decide on stalls.

---
 rtl/reg_file_sb.sv | 89 ++++++++
 tb/tb_reg_file_sb.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Parametrised 2-read/1-write register file with hardwired zero register and per-register busy scoreboard.
// Optional write-through forwarding on the read ports when REG_FILE_BYPASS_EN is defined.
module reg_file_sb #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              rd_busy1,
   output logic              rd_busy2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic              rsv_ok,
   input  logic              flush
);
   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_busy;

   logic w_zero_rd1;
   logic w_zero_rd2;
   logic w_zero_wr;
   logic w_zero_rsv;
   logic w_wr_act;
   logic w_rsv_ok;

   assign w_zero_rd1 = (ZERO_REG != 0) && (rd_addr1 == '0);
   assign w_zero_rd2 = (ZERO_REG != 0) && (rd_addr2 == '0);
   assign w_zero_wr  = (ZERO_REG != 0) && (wr_addr  == '0);
   assign w_zero_rsv = (ZERO_REG != 0) && (rsv_addr == '0);
   assign w_wr_act   = wr_en && !w_zero_wr;

   // A same-cycle writeback to the requested register frees it, so the reservation is granted.
   assign w_rsv_ok = rst && rsv_en && !flush && !w_zero_rsv &&
                     (!r_busy[rsv_addr] || (wr_en && (wr_addr == rsv_addr)));
   assign rsv_ok   = w_rsv_ok;

   always_comb begin
      rd_data1 = w_zero_rd1 ? '0 : r_mem[rd_addr1];
      rd_busy1 = !w_zero_rd1 && r_busy[rd_addr1];
      rd_data2 = w_zero_rd2 ? '0 : r_mem[rd_addr2];
      rd_busy2 = !w_zero_rd2 && r_busy[rd_addr2];
`ifdef REG_FILE_BYPASS_EN
      if (rst && w_wr_act && (wr_addr == rd_addr1)) begin
         rd_data1 = wr_data;
         rd_busy1 = 1'b0;
      end
      if (rst && w_wr_act && (wr_addr == rd_addr2)) begin
         rd_data2 = wr_data;
         rd_busy2 = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_act) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   // Later assignments win: reservation set overrides the writeback clear; flush overrides both.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy <= '0;
      end else if (flush) begin
         r_busy <= '0;
      end else begin
         if (w_wr_act) begin
            r_busy[wr_addr] <= 1'b0;
         end
         if (w_rsv_ok) begin
            r_busy[rsv_addr] <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: table of per-cycle vectors with a scoreboard queue,
// plus hand-written sequences for reset, forwarding (REG_FILE_BYPASS_EN) and asynchronous reset.
module tb_reg_file_sb;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] rd_addr1, rd_addr2, wr_addr, rsv_addr;
   logic [DW-1:0] rd_data1, rd_data2, wr_data;
   logic          rd_busy1, rd_busy2, wr_en, rsv_en, rsv_ok, flush;

   reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1), .rd_data2(rd_data2),
      .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
      .flush(flush)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          wr_en;
      logic [AW-1:0] wr_addr;
      logic [DW-1:0] wr_data;
      logic          rsv_en;
      logic [AW-1:0] rsv_addr;
      logic          flush;
      logic [AW-1:0] ra1;
      logic [AW-1:0] ra2;
      logic          ok;
      logic [DW-1:0] d1;
      logic          b1;
      logic [DW-1:0] d2;
      logic          b2;
   } vec_t;

   typedef struct {
      logic [DW-1:0] d1;
      logic          b1;
      logic [DW-1:0] d2;
      logic          b2;
   } exp_t;

   vec_t vecs[14];
   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic we, input int wa, input logic [DW-1:0] wd,
                               input logic re, input int rsa, input logic fl,
                               input int a1, input int a2, input logic ok,
                               input logic [DW-1:0] d1, input logic b1,
                               input logic [DW-1:0] d2, input logic b2);
      vec_t v;
      v.wr_en = we;  v.wr_addr = AW'(wa);  v.wr_data = wd;
      v.rsv_en = re; v.rsv_addr = AW'(rsa); v.flush = fl;
      v.ra1 = AW'(a1); v.ra2 = AW'(a2); v.ok = ok;
      v.d1 = d1; v.b1 = b1; v.d2 = d2; v.b2 = b2;
      return v;
   endfunction

   task automatic idle_inputs();
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
   endtask

   initial begin : watchdog
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      // Vectors: write/reserve/flush inputs, read addresses, expected rsv_ok this cycle,
      // then expected read data/busy one cycle later with write/reserve idle.
      vecs[0]  = mk(0,  0, 32'h0,        0,  0, 0,  5, 31, 0, 32'h0,        0, 32'h0,        0);
      vecs[1]  = mk(1,  2, 32'd25,       0,  0, 0,  2,  1, 0, 32'd25,       0, 32'h0,        0);
      vecs[2]  = mk(1,  0, 32'hDEADBEEF, 1,  0, 0,  0,  2, 0, 32'h0,        0, 32'd25,       0);
      vecs[3]  = mk(0,  0, 32'h0,        1,  7, 0,  7,  0, 1, 32'h0,        1, 32'h0,        0);
      vecs[4]  = mk(0,  0, 32'h0,        1,  7, 0,  7,  7, 0, 32'h0,        1, 32'h0,        1);
      vecs[5]  = mk(1,  7, 32'h1234,     0,  0, 0,  7,  0, 0, 32'h1234,     0, 32'h0,        0);
      vecs[6]  = mk(0,  0, 32'h0,        1,  9, 0,  9,  7, 1, 32'h0,        1, 32'h1234,     0);
      vecs[7]  = mk(1,  9, 32'd77,       1,  9, 0,  9,  9, 1, 32'd77,       1, 32'd77,       1);
      vecs[8]  = mk(0,  0, 32'h0,        1,  3, 0,  3,  9, 1, 32'h0,        1, 32'd77,       1);
      vecs[9]  = mk(1,  3, 32'h33,       1,  4, 0,  3,  4, 1, 32'h33,       0, 32'h0,        1);
      vecs[10] = mk(1,  4, 32'h44,       1,  5, 1,  4,  9, 0, 32'h44,       0, 32'd77,       0);
      vecs[11] = mk(0,  0, 32'h0,        1, 31, 0, 31, 31, 1, 32'h0,        1, 32'h0,        1);
      vecs[12] = mk(1, 31, 32'hFFFFFFFF, 0,  0, 0, 31,  3, 0, 32'hFFFFFFFF, 0, 32'h33,       0);
      vecs[13] = mk(1,  5, 32'h55,       1,  7, 0,  7,  5, 1, 32'h1234,     1, 32'h55,       0);

      // Reset held: everything reads zero and reservations are refused.
      rst = 1'b0;
      idle_inputs();
      rd_addr1 = 5'd5; rd_addr2 = 5'd31;
      rsv_en = 1'b1; rsv_addr = 5'd7;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_d1",  rd_data1, '0);
      chk("reset_d2",  rd_data2, '0);
      chk("reset_b1",  {31'b0, rd_busy1}, '0);
      chk("reset_b2",  {31'b0, rd_busy2}, '0);
      chk("reset_rsv_ok", {31'b0, rsv_ok}, '0);
      idle_inputs();
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
         rsv_en = vecs[i].rsv_en; rsv_addr = vecs[i].rsv_addr; flush = vecs[i].flush;
         rd_addr1 = vecs[i].ra1; rd_addr2 = vecs[i].ra2;
         #1;
         chk($sformatf("v%0d_rsv_ok", i), {31'b0, rsv_ok}, {31'b0, vecs[i].ok});
         sb.push_back('{d1: vecs[i].d1, b1: vecs[i].b1, d2: vecs[i].d2, b2: vecs[i].b2});
         @(posedge clk);
         #1;
         idle_inputs();
         #1;
         e = sb.pop_front();
         chk($sformatf("v%0d_d1", i), rd_data1, e.d1);
         chk($sformatf("v%0d_b1", i), {31'b0, rd_busy1}, {31'b0, e.b1});
         chk($sformatf("v%0d_d2", i), rd_data2, e.d2);
         chk($sformatf("v%0d_b2", i), {31'b0, rd_busy2}, {31'b0, e.b2});
      end

      // Write-cycle visibility: reserve 6, then write it while reading it.
      @(negedge clk);
      rsv_en = 1'b1; rsv_addr = 5'd6;
      @(negedge clk);
      idle_inputs();
      wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
      rd_addr1 = 5'd6; rd_addr2 = 5'd6;
      #1;
`ifdef REG_FILE_BYPASS_EN
      chk("wcycle_d1", rd_data1, 32'h66);
      chk("wcycle_b2", {31'b0, rd_busy2}, '0);
`else
      chk("wcycle_d1", rd_data1, 32'h0);
      chk("wcycle_b2", {31'b0, rd_busy2}, 32'h1);
`endif
      @(negedge clk);
      idle_inputs();
      #1;
      chk("wpost_d1", rd_data1, 32'h66);
      chk("wpost_b1", {31'b0, rd_busy1}, '0);

      // Asynchronous reset between edges with a live reservation on 3.
      @(negedge clk);
      rsv_en = 1'b1; rsv_addr = 5'd3;
      @(negedge clk);
      idle_inputs();
      rd_addr1 = 5'd3; rd_addr2 = 5'd2;
      #1;
      chk("pre_arst_b1", {31'b0, rd_busy1}, 32'h1);
      chk("pre_arst_d2", rd_data2, 32'd25);
      #1;
      rst = 1'b0;
      rsv_en = 1'b1; rsv_addr = 5'd10;
      #1;
      chk("arst_b1", {31'b0, rd_busy1}, '0);
      chk("arst_d1", rd_data1, '0);
      chk("arst_d2", rd_data2, '0);
      chk("arst_rsv_ok", {31'b0, rsv_ok}, '0);
      idle_inputs();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("post_arst_d2", rd_data2, '0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
